// File: rtl/lcd_win_proc.sv
// lcd_win_proc: LCD image-buffer controller.
// Loads IMG_W x IMG_H pixels from IROM, applies 2x2 window commands
// (shift, max/min/avg, rotate, mirror, reload) and streams the image to IRAM.
module lcd_win_proc #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] rom_q,
  output logic              rom_rd,
  output logic [AW-1:0]     rom_addr,
  output logic              ram_valid,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 2);
  localparam logic [XW-1:0] X_RST = XW'(IMG_W / 2 - 1);
  localparam logic [YW-1:0] Y_RST = YW'(IMG_H / 2 - 1);
  localparam logic [AW-1:0] A_LAST = '1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    C_WRITE  = 4'd0,
    C_UP     = 4'd1,
    C_DOWN   = 4'd2,
    C_LEFT   = 4'd3,
    C_RIGHT  = 4'd4,
    C_MAX    = 4'd5,
    C_MIN    = 4'd6,
    C_AVG    = 4'd7,
    C_CCW    = 4'd8,
    C_CW     = 4'd9,
    C_MIRX   = 4'd10,
    C_MIRY   = 4'd11,
    C_RELOAD = 4'd12
  } cmd_e;

  state_e              state_q;
  cmd_e                cmd_q;
  logic [AW:0]         cnt_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic                rom_rd_q;
  logic                busy_q;
  logic                ram_valid_q;
  logic [AW-1:0]       ram_addr_q;
  logic                done_q;

  logic [DATA_W-1:0]   img_q [N];

  logic [AW:0]         cnt_nx;
  logic [AW-1:0]       ld_addr;
  logic [XW-1:0]       x_nx;
  logic [YW-1:0]       y_nx;
  logic [AW-1:0]       a0, a1, a2, a3;
  logic [DATA_W-1:0]   p0, p1, p2, p3;
  logic [DATA_W-1:0]   max01, max23, max_all;
  logic [DATA_W-1:0]   min01, min23, min_all;
  logic [DATA_W+1:0]   sum;
  logic [DATA_W-1:0]   avg;
  logic [DATA_W-1:0]   n0, n1, n2, n3;
  logic                win_we;

  // Load counter doubles as the IROM address; the slot written lags it by one
  // cycle because IROM data returns one cycle after the address.
  assign cnt_nx   = cnt_q + 1'b1;
  assign ld_addr  = cnt_q[AW-1:0] - 1'b1;
  assign rom_addr = cnt_q[AW-1:0];

  // Window pixel addresses: y*IMG_W + x is a plain concatenation for power-of-two widths.
  assign x_nx = x_q + XW'(1);
  assign y_nx = y_q + YW'(1);
  assign a0   = {y_q,  x_q};
  assign a1   = {y_q,  x_nx};
  assign a2   = {y_nx, x_q};
  assign a3   = {y_nx, x_nx};

  assign p0 = img_q[a0];
  assign p1 = img_q[a1];
  assign p2 = img_q[a2];
  assign p3 = img_q[a3];

  assign rom_rd    = rom_rd_q;
  assign busy      = busy_q;
  assign ram_valid = ram_valid_q;
  assign ram_addr  = ram_addr_q;
  assign done      = done_q;
  assign ram_d     = img_q[ram_addr_q];

  // Window arithmetic: reductions over the four pre-command pixels.
  always_comb begin
    max01   = (p0 > p1) ? p0 : p1;
    max23   = (p2 > p3) ? p2 : p3;
    max_all = (max01 > max23) ? max01 : max23;
    min01   = (p0 < p1) ? p0 : p1;
    min23   = (p2 < p3) ? p2 : p3;
    min_all = (min01 < min23) ? min01 : min23;
    sum     = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    avg     = DATA_W'(sum >> 2);
  end

  // New window contents for the latched command.
  always_comb begin
    n0     = p0;
    n1     = p1;
    n2     = p2;
    n3     = p3;
    win_we = 1'b0;
    case (cmd_q)
      C_MAX: begin
        n0 = max_all; n1 = max_all; n2 = max_all; n3 = max_all; win_we = 1'b1;
      end
      C_MIN: begin
        n0 = min_all; n1 = min_all; n2 = min_all; n3 = min_all; win_we = 1'b1;
      end
      C_AVG: begin
        n0 = avg; n1 = avg; n2 = avg; n3 = avg; win_we = 1'b1;
      end
      C_CCW: begin
        n0 = p1; n1 = p3; n3 = p2; n2 = p0; win_we = 1'b1;
      end
      C_CW: begin
        n0 = p2; n1 = p0; n3 = p1; n2 = p3; win_we = 1'b1;
      end
      C_MIRX: begin
        n0 = p2; n2 = p0; n1 = p3; n3 = p1; win_we = 1'b1;
      end
      C_MIRY: begin
        n0 = p1; n1 = p0; n2 = p3; n3 = p2; win_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Image storage: IROM capture during LOAD, all four window writes on one edge in EXEC.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && cnt_q != '0) begin
      img_q[ld_addr] <= rom_q;
    end else if (state_q == S_EXEC && win_we) begin
      img_q[a0] <= n0;
      img_q[a1] <= n1;
      img_q[a2] <= n2;
      img_q[a3] <= n3;
    end
  end

  // Control FSM with registered handshake outputs and window origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      cmd_q       <= C_WRITE;
      cnt_q       <= '0;
      x_q         <= X_RST;
      y_q         <= Y_RST;
      rom_rd_q    <= 1'b1;
      busy_q      <= 1'b1;
      ram_valid_q <= 1'b0;
      ram_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (cnt_q[AW]) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q    <= cnt_nx;
            rom_rd_q <= ~cnt_nx[AW];
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q  <= cmd_e'(cmd);
            busy_q <= 1'b1;
            if (cmd == C_WRITE) begin
              state_q     <= S_WRITE;
              ram_valid_q <= 1'b1;
              ram_addr_q  <= '0;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          case (cmd_q)
            C_UP:    if (y_q != '0)   y_q <= y_q - YW'(1);
            C_DOWN:  if (y_q != Y_MAX) y_q <= y_nx;
            C_LEFT:  if (x_q != '0)   x_q <= x_q - XW'(1);
            C_RIGHT: if (x_q != X_MAX) x_q <= x_nx;
            C_RELOAD: begin
              state_q  <= S_LOAD;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              rom_rd_q <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WRITE: begin
          if (ram_addr_q == A_LAST) begin
            state_q     <= S_DONE;
            ram_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            ram_addr_q <= ram_addr_q + 1'b1;
          end
        end
        S_DONE: begin
          if (cmd_valid && cmd == C_RELOAD) begin
            state_q  <= S_LOAD;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            rom_rd_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_LOAD;
          cnt_q    <= '0;
          rom_rd_q <= 1'b1;
          busy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
